// File: rtl/ram_lru_nbuf_pkg.sv
// Shared types and helpers for the N-buffer frame store.
// Index queues are packed arrays sized for the largest supported bank count.
// Entry 0 is the head; pushes land at the current count position.
package ram_lru_nbuf_pkg;

    localparam int unsigned MAX_NBUF  = 8;
    localparam int unsigned IDX_MAX_W = 3;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [0:0] {
        MODE_LATEST = 1'b0,
        MODE_FIFO   = 1'b1
    } lru_mode_t;

    typedef logic [IDX_MAX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;
    typedef idx_t [MAX_NBUF-1:0]  idx_queue_t;

    // Write val at the tail position (pos = current occupancy)
    function automatic idx_queue_t q_push(idx_queue_t q, idx_t pos, idx_t val);
        idx_queue_t r;
        r      = q;
        r[pos] = val;
        return r;
    endfunction

    // Drop the head entry; everything moves one place toward the head
    function automatic idx_queue_t q_pop(idx_queue_t q);
        return idx_queue_t'({idx_t'(0), q[MAX_NBUF-1:1]});
    endfunction

    // Free pool after reset: banks 2..nbuf-1 in ascending order
    function automatic idx_queue_t free_init(int unsigned nbuf);
        idx_queue_t q;
        q = '0;
        for (int unsigned i = 2; i < nbuf; i++) begin
            q[IDX_MAX_W'(i - 2)] = idx_t'(i);
        end
        return q;
    endfunction

endpackage

// File: rtl/ram_lru_nbuf_if.sv
// Writer/reader bus of the N-buffer frame store.
// slave : the frame store (takes write/read strobes, drives data and status)
// master: the environment (video writer + panel reader)
interface ram_lru_nbuf_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned NBUF   = 4
);
    localparam int unsigned IDX_W = $clog2(NBUF);

    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_enab;
    logic              write_done;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;
    logic              read_done;
    logic              bypass_lru;
    logic              fifo_mode;
    logic              write_ready;
    logic              read_fresh;
    logic [IDX_W:0]    ready_count;
    logic [IDX_W-1:0]  write_buf;
    logic [IDX_W-1:0]  read_buf;
    logic              frame_dropped;
    logic              frame_repeat;
    logic              write_overflow;

    modport slave (
        input  write_addr, write_data, write_enab, write_done,
        input  read_addr, read_done, bypass_lru, fifo_mode,
        output read_data, write_ready, read_fresh, ready_count,
        output write_buf, read_buf, frame_dropped, frame_repeat, write_overflow
    );

    modport master (
        output write_addr, write_data, write_enab, write_done,
        output read_addr, read_done, bypass_lru, fifo_mode,
        input  read_data, write_ready, read_fresh, ready_count,
        input  write_buf, read_buf, frame_dropped, frame_repeat, write_overflow
    );

endinterface

// File: rtl/ram_lru_nbuf_sdp_ram.sv
// Simple dual-port RAM bank with one-cycle registered read (read-before-write).
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out (registered).
module lru_sdp_ram #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_lru_nbuf.sv
// N-buffer frame store between a video-stream writer and an LED-panel reader.
// One bank is written, one is read, the rest sit in a ready queue (oldest
// first) or a free pool. LATEST mode drops stale frames; FIFO mode keeps
// every frame and rejects a completed frame when no free bank is left.
// Ports: clk, rst (async, active-high); bus (slave side of ram_lru_nbuf_if).
module ram_lru_nbuf
    import ram_lru_nbuf_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned NBUF   = 4
) (
    input  logic          clk,
    input  logic          rst,
    ram_lru_nbuf_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NBUF);
    localparam int unsigned RC_W  = IDX_W + 1;
    localparam idx_queue_t  FREE_INIT = free_init(NBUF);

    logic [IDX_W-1:0] wr_buf_q, rd_buf_q, rd_sel_q;
    idx_queue_t       free_q, rdy_q;
    cnt_t             free_cnt_q, rdy_cnt_q;
    logic             fresh_q, wd_q, rd_q, wr_ready_q;
    logic             dropped_q, repeat_q, ovf_q;

    logic [IDX_W-1:0] wr_buf_n, rd_buf_n;
    idx_queue_t       free_n, rdy_n;
    cnt_t             free_cnt_n, rdy_cnt_n;
    logic             fresh_n, dropped_n, repeat_n, ovf_n, reject;
    logic             wd_ev, rd_ev;
    lru_mode_t        mode;

    assign mode  = lru_mode_t'(bus.fifo_mode);
    assign wd_ev = bus.write_done && !wd_q;
    assign rd_ev = bus.read_done && !rd_q;

    // Bank bookkeeping: push, read swap, allocate -- in that order within a cycle
    always_comb begin
        wr_buf_n   = wr_buf_q;
        rd_buf_n   = rd_buf_q;
        free_n     = free_q;
        rdy_n      = rdy_q;
        free_cnt_n = free_cnt_q;
        rdy_cnt_n  = rdy_cnt_q;
        fresh_n    = fresh_q;
        dropped_n  = 1'b0;
        repeat_n   = 1'b0;
        ovf_n      = 1'b0;

        // A simultaneous read always frees a bank, so only a lone write can be rejected
        reject = (mode == MODE_FIFO) && wd_ev && !rd_ev && (free_cnt_q == '0);

        if (wd_ev && !reject) begin
            rdy_n     = q_push(rdy_n, IDX_MAX_W'(rdy_cnt_n), idx_t'(wr_buf_q));
            rdy_cnt_n = rdy_cnt_n + cnt_t'(1);
        end

        if (rd_ev) begin
            if (rdy_cnt_n != '0) begin
                free_n     = q_push(free_n, IDX_MAX_W'(free_cnt_n), idx_t'(rd_buf_q));
                free_cnt_n = free_cnt_n + cnt_t'(1);
                fresh_n    = 1'b1;
                if (mode == MODE_FIFO) begin
                    rd_buf_n  = IDX_W'(rdy_n[0]);
                    rdy_n     = q_pop(rdy_n);
                    rdy_cnt_n = rdy_cnt_n - cnt_t'(1);
                end else begin
                    rd_buf_n = IDX_W'(rdy_n[IDX_MAX_W'(rdy_cnt_n - cnt_t'(1))]);
                    // Everything older than the newest frame is discarded
                    for (int unsigned i = 0; i < MAX_NBUF; i++) begin
                        if ((cnt_t'(i) + cnt_t'(1)) < rdy_cnt_n) begin
                            free_n     = q_push(free_n, IDX_MAX_W'(free_cnt_n), rdy_n[IDX_MAX_W'(i)]);
                            free_cnt_n = free_cnt_n + cnt_t'(1);
                            dropped_n  = 1'b1;
                        end
                    end
                    rdy_n     = '0;
                    rdy_cnt_n = '0;
                end
            end else begin
                fresh_n  = 1'b0;
                repeat_n = 1'b1;
            end
        end

        if (wd_ev) begin
            if (reject) begin
                ovf_n = 1'b1;
            end else if (free_cnt_n != '0) begin
                wr_buf_n   = IDX_W'(free_n[0]);
                free_n     = q_pop(free_n);
                free_cnt_n = free_cnt_n - cnt_t'(1);
            end else begin
                // LATEST only: recycle the oldest ready frame
                wr_buf_n  = IDX_W'(rdy_n[0]);
                rdy_n     = q_pop(rdy_n);
                rdy_cnt_n = rdy_cnt_n - cnt_t'(1);
                dropped_n = 1'b1;
            end
        end
    end

    // State and registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_buf_q   <= IDX_W'(0);
            rd_buf_q   <= IDX_W'(1);
            rd_sel_q   <= IDX_W'(0);
            free_q     <= FREE_INIT;
            rdy_q      <= '0;
            free_cnt_q <= cnt_t'(NBUF - 2);
            rdy_cnt_q  <= '0;
            fresh_q    <= 1'b0;
            wd_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_ready_q <= 1'b1;
            dropped_q  <= 1'b0;
            repeat_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_buf_q   <= wr_buf_n;
            rd_buf_q   <= rd_buf_n;
            // Select is captured with the address so a swap cannot hit the word in flight
            rd_sel_q   <= bus.bypass_lru ? wr_buf_q : rd_buf_q;
            free_q     <= free_n;
            rdy_q      <= rdy_n;
            free_cnt_q <= free_cnt_n;
            rdy_cnt_q  <= rdy_cnt_n;
            fresh_q    <= fresh_n;
            wd_q       <= bus.write_done;
            rd_q       <= bus.read_done;
            wr_ready_q <= (mode == MODE_LATEST) || (free_cnt_n != '0);
            dropped_q  <= dropped_n;
            repeat_q   <= repeat_n;
            ovf_q      <= ovf_n;
        end
    end

    // Bank array
    logic [DATA_W-1:0] bank_rdata [NBUF];

    for (genvar b = 0; b < NBUF; b++) begin : g_bank
        lru_sdp_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (bus.write_enab && (wr_buf_q == IDX_W'(b))),
            .waddr (bus.write_addr),
            .wdata (bus.write_data),
            .raddr (bus.read_addr),
            .rdata (bank_rdata[b])
        );
    end

    assign bus.read_data      = bank_rdata[rd_sel_q];
    assign bus.write_buf      = wr_buf_q;
    assign bus.read_buf       = rd_buf_q;
    assign bus.ready_count    = RC_W'(rdy_cnt_q);
    assign bus.read_fresh     = fresh_q;
    assign bus.write_ready    = wr_ready_q;
    assign bus.frame_dropped  = dropped_q;
    assign bus.frame_repeat   = repeat_q;
    assign bus.write_overflow = ovf_q;

endmodule

// File: tb/tb_ram_lru_nbuf.sv
// Directed bench for ram_lru_nbuf (NBUF=4, DATA_W=24, ADDR_W=7).
module tb_ram_lru_nbuf;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned NBUF   = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ram_lru_nbuf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBUF(NBUF)) bus ();

    ram_lru_nbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBUF(NBUF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.write_addr = a;
        bus.write_data = d;
        bus.write_enab = 1'b1;
        step();
        bus.write_enab = 1'b0;
    endtask

    task automatic wd_pulse();
        bus.write_done = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.write_enab = 1'b0;
        bus.write_done = 1'b0;
        bus.read_addr  = '0;
        bus.read_done  = 1'b0;
        bus.bypass_lru = 1'b0;
        bus.fifo_mode  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // 1: reset state
        chk("rst_write_buf", 32'(bus.write_buf), 32'd0);
        chk("rst_read_buf", 32'(bus.read_buf), 32'd1);
        chk("rst_ready_count", 32'(bus.ready_count), 32'd0);
        chk("rst_write_ready", 32'(bus.write_ready), 32'd1);
        chk("rst_read_fresh", 32'(bus.read_fresh), 32'd0);
        chk("rst_pulses", 32'({bus.frame_dropped, bus.frame_repeat, bus.write_overflow}), 32'd0);

        // 2: single frame through
        write_word(7'd5, 24'hABCDEF);
        wd_pulse();
        chk("t2_write_buf", 32'(bus.write_buf), 32'd2);
        chk("t2_ready_count", 32'(bus.ready_count), 32'd1);
        bus.write_done = 1'b0;
        bus.read_done  = 1'b1;
        step();
        chk("t2_read_buf", 32'(bus.read_buf), 32'd0);
        chk("t2_read_fresh", 32'(bus.read_fresh), 32'd1);
        bus.read_done = 1'b0;
        bus.read_addr = 7'd5;
        step();
        chk("t2_read_data", 32'(bus.read_data), 32'hABCDEF);

        // 3: LATEST, writer outruns reader
        do_reset();
        write_word(7'd9, 24'h111111);
        wd_pulse();
        bus.write_done = 1'b0;
        write_word(7'd9, 24'h222222);
        wd_pulse();
        bus.write_done = 1'b0;
        write_word(7'd9, 24'h333333);
        wd_pulse();
        chk("t3_dropped", 32'(bus.frame_dropped), 32'd1);
        chk("t3_write_buf", 32'(bus.write_buf), 32'd0);
        chk("t3_ready_count", 32'(bus.ready_count), 32'd2);
        chk("t3_write_ready", 32'(bus.write_ready), 32'd1);
        bus.write_done = 1'b0;
        step();
        chk("t3_dropped_end", 32'(bus.frame_dropped), 32'd0);
        bus.read_done = 1'b1;
        step();
        chk("t3_read_buf", 32'(bus.read_buf), 32'd3);
        chk("t3_rd_ready_count", 32'(bus.ready_count), 32'd0);
        chk("t3_rd_dropped", 32'(bus.frame_dropped), 32'd1);
        bus.read_done = 1'b0;
        bus.read_addr = 7'd9;
        step();
        chk("t3_read_data", 32'(bus.read_data), 32'h333333);

        // 4: FIFO, same stimulus
        bus.fifo_mode = 1'b1;
        do_reset();
        write_word(7'd9, 24'h444444);
        wd_pulse();
        chk("t4_ready_e1", 32'(bus.write_ready), 32'd1);
        bus.write_done = 1'b0;
        write_word(7'd9, 24'h555555);
        wd_pulse();
        bus.write_done = 1'b0;
        write_word(7'd9, 24'h666666);
        wd_pulse();
        chk("t4_overflow", 32'(bus.write_overflow), 32'd1);
        chk("t4_write_ready", 32'(bus.write_ready), 32'd0);
        chk("t4_write_buf", 32'(bus.write_buf), 32'd3);
        chk("t4_ready_count", 32'(bus.ready_count), 32'd2);
        bus.write_done = 1'b0;
        step();
        chk("t4_overflow_end", 32'(bus.write_overflow), 32'd0);
        bus.read_done = 1'b1;
        step();
        chk("t4_read_buf", 32'(bus.read_buf), 32'd0);
        chk("t4_rd_ready_count", 32'(bus.ready_count), 32'd1);
        chk("t4_rd_write_ready", 32'(bus.write_ready), 32'd1);
        chk("t4_rd_write_buf", 32'(bus.write_buf), 32'd3);
        bus.read_done = 1'b0;
        bus.read_addr = 7'd9;
        step();
        chk("t4_read_data", 32'(bus.read_data), 32'h444444);

        // 5: simultaneous write_done and read_done
        bus.fifo_mode = 1'b0;
        do_reset();
        write_word(7'd3, 24'hC0FFEE);
        bus.write_done = 1'b1;
        bus.read_done  = 1'b1;
        step();
        chk("t5_read_buf", 32'(bus.read_buf), 32'd0);
        chk("t5_write_buf", 32'(bus.write_buf), 32'd2);
        chk("t5_ready_count", 32'(bus.ready_count), 32'd0);
        chk("t5_read_fresh", 32'(bus.read_fresh), 32'd1);
        bus.write_done = 1'b0;
        bus.read_done  = 1'b0;
        bus.read_addr  = 7'd3;
        step();
        chk("t5_read_data", 32'(bus.read_data), 32'hC0FFEE);

        // 6: repeat, held level, bypass, mid-frame reset
        do_reset();
        bus.read_done = 1'b1;
        step();
        chk("t6_repeat", 32'(bus.frame_repeat), 32'd1);
        chk("t6_read_buf", 32'(bus.read_buf), 32'd1);
        chk("t6_read_fresh", 32'(bus.read_fresh), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t6_held_repeat", 32'(bus.frame_repeat), 32'd0);
        end
        bus.read_done = 1'b0;
        step();

        bus.bypass_lru = 1'b1;
        write_word(7'd7, 24'h5A5A5A);
        bus.read_addr = 7'd7;
        step();
        chk("t6_bypass_rd", 32'(bus.read_data), 32'h5A5A5A);
        bus.write_data = 24'h123456;
        bus.write_enab = 1'b1;
        step();
        chk("t6_bypass_old", 32'(bus.read_data), 32'h5A5A5A);
        bus.write_enab = 1'b0;
        step();
        chk("t6_bypass_new", 32'(bus.read_data), 32'h123456);
        bus.bypass_lru = 1'b0;

        wd_pulse();
        chk("t6_pre_rst_wbuf", 32'(bus.write_buf), 32'd2);
        bus.write_done = 1'b0;
        bus.write_enab = 1'b1;
        rst = 1'b1;
        step();
        chk("t6_rst_write_buf", 32'(bus.write_buf), 32'd0);
        chk("t6_rst_read_buf", 32'(bus.read_buf), 32'd1);
        chk("t6_rst_ready_count", 32'(bus.ready_count), 32'd0);
        chk("t6_rst_write_ready", 32'(bus.write_ready), 32'd1);
        rst = 1'b0;
        bus.write_enab = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
